// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce.
// Keeps the last two accepted hex keys for a two-digit display.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4800,
    parameter int DEBOUNCE_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_valid
);

    localparam int DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DbW  = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]  DbMax   = DbW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        REL_DB
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     rows_m_q, rows_s_q;
    logic [DivW-1:0] div_q;
    logic [1:0]     col_q, col_d;
    logic [1:0]     row_q, row_d;
    logic [DbW-1:0] db_q, db_d;
    logic [3:0]     new_q, new_d;
    logic [3:0]     old_q, old_d;
    logic           valid_q, valid_d;

    logic           tick;
    logic           key_low;
    logic [1:0]     first_low;
    logic [DbW-1:0] db_inc;

    function automatic logic [3:0] key_code(input logic [1:0] r,
                                            input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_m_q <= 4'hF;
            rows_s_q <= 4'hF;
            div_q    <= '0;
        end else begin
            rows_m_q <= rows;
            rows_s_q <= rows_m_q;
            div_q    <= tick ? '0 : div_q + 1'b1;
        end
    end

    assign tick    = (div_q == DivLast);
    assign key_low = ~rows_s_q[row_q];
    assign db_inc  = (db_q == DbMax) ? db_q : db_q + 1'b1;

    // Lowest-index low row wins when several rows are low
    always_comb begin
        first_low = 2'd3;
        if (!rows_s_q[0])      first_low = 2'd0;
        else if (!rows_s_q[1]) first_low = 2'd1;
        else if (!rows_s_q[2]) first_low = 2'd2;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        db_d    = db_q;
        new_d   = new_q;
        old_d   = old_q;
        valid_d = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rows_s_q == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = first_low;
                        db_d    = '0;
                        state_d = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (key_low) begin
                        db_d = db_inc;
                        if (db_inc == DbMax) begin
                            old_d   = new_q;
                            new_d   = key_code(row_q, col_q);
                            valid_d = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!key_low) begin
                        db_d    = '0;
                        state_d = REL_DB;
                    end
                end
                default: begin
                    if (!key_low) begin
                        db_d = db_inc;
                        if (db_inc == DbMax) begin
                            col_d   = col_q + 2'd1;
                            state_d = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            db_q    <= '0;
            new_q   <= 4'h0;
            old_q   <= 4'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            db_q    <= db_d;
            new_q   <= new_d;
            old_q   <= old_d;
            valid_q <= valid_d;
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign digit_new = new_q;
    assign digit_old = old_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model, commit scoreboard, directed scenarios.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  digit_new;
    logic [3:0]  digit_old;
    logic        key_valid;
    logic [15:0] pressed = '0;

    int          nvec = 0;
    int          nerr = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_e;
    logic [3:0]  cseq[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .digit_new(digit_new),
        .digit_old(digit_old),
        .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is driven low
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_pulse: got digits %h%h, expected none",
                         digit_new, digit_old);
            end else begin
                exp_e = exp_q.pop_front();
                chk("commit_digits", 32'({digit_new, digit_old}), 32'(exp_e));
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n * SD) @(negedge clk);
    endtask

    task automatic wait_cols(input logic [3:0] v, input string name);
        for (int i = 0; i < 64 && cols !== v; i++) @(negedge clk);
        chk(name, 32'(cols), 32'(v));
    endtask

    initial begin
        int         cnt;
        logic [3:0] prev;

        // Reset and free scanning
        repeat (10) @(negedge clk);
        chk("reset_cols", 32'(cols), 32'(4'b1110));
        chk("reset_digits", 32'({digit_new, digit_old}), 32'h00);
        chk("reset_valid", 32'(key_valid), 32'h0);
        reset = 1'b1;
        chk("post_reset_cols", 32'(cols), 32'(4'b1110));
        for (int i = 0; i < 4; i++) begin
            cnt  = 0;
            prev = cols;
            while (cols === prev && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            chk("scan_cols", 32'(cols), 32'(cseq[i]));
            chk("scan_period", 32'(cnt), 32'(SD));
        end

        // Clean press of '5'
        exp_q.push_back({4'h5, 4'h0});
        pressed[1*4+1] = 1'b1;
        ticks(20);
        chk("hold5_cols", 32'(cols), 32'(4'b1101));
        chk("hold5_digits", 32'({digit_new, digit_old}), 32'h50);
        pressed = '0;
        ticks(10);
        chk("after5_queue", 32'(exp_q.size()), 32'h0);

        // Second key 'A'
        exp_q.push_back({4'hA, 4'h5});
        pressed[0*4+3] = 1'b1;
        ticks(20);
        chk("holdA_cols", 32'(cols), 32'(4'b0111));
        pressed = '0;
        ticks(10);
        chk("afterA_digits", 32'({digit_new, digit_old}), 32'hA5);
        chk("afterA_queue", 32'(exp_q.size()), 32'h0);

        // Two-tick glitch on '9'
        wait_cols(4'b1011, "glitch_align");
        pressed[2*4+2] = 1'b1;
        repeat (2 * SD) @(negedge clk);
        pressed = '0;
        ticks(10);
        chk("glitch_digits", 32'({digit_new, digit_old}), 32'hA5);
        chk("glitch_queue", 32'(exp_q.size()), 32'h0);
        wait_cols(4'b0111, "glitch_resume");

        // Bouncy hold of '0' with '7' pressed mid-hold
        exp_q.push_back({4'h0, 4'hA});
        pressed[3*4+1] = 1'b1;
        ticks(1);
        pressed[3*4+1] = 1'b0;
        ticks(1);
        pressed[3*4+1] = 1'b1;
        ticks(100);
        pressed[2*4+0] = 1'b1;
        ticks(50);
        pressed[2*4+0] = 1'b0;
        ticks(50);
        chk("hold0_cols", 32'(cols), 32'(4'b1101));
        pressed[3*4+1] = 1'b0;
        ticks(1);
        pressed[3*4+1] = 1'b1;
        ticks(1);
        pressed[3*4+1] = 1'b0;
        ticks(20);
        chk("after0_digits", 32'({digit_new, digit_old}), 32'h0A);
        chk("after0_queue", 32'(exp_q.size()), 32'h0);

        // Reset during press debounce of 'F'
        wait_cols(4'b1011, "f_align");
        pressed[3*4+2] = 1'b1;
        ticks(2);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'({digit_new, digit_old}), 32'h00);
        chk("rst_cols", 32'(cols), 32'(4'b1110));
        chk("rst_valid", 32'(key_valid), 32'h0);
        pressed = '0;
        reset = 1'b1;
        chk("rst_rel_cols", 32'(cols), 32'(4'b1110));
        ticks(10);
        chk("rst_after_digits", 32'({digit_new, digit_old}), 32'h00);
        chk("final_queue", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and registers the two most recent hex keys. It sits directly upstream of the dual seven-segment multiplexer: `digit_new` and `digit_old` drive its two 4-bit digit inputs in place of DIP switches. The block registers exactly one key per physical press, regardless of contact bounce or hold duration.

## Interface
- `SCAN_DIV`, default 4800: clk cycles per scan tick (200 µs at 24 MHz); must be ≥ 2.
- `DEBOUNCE_TICKS`, default 100: consecutive stable scan ticks (20 ms) needed to accept a press or a release; must be ≥ 1.
- `clk`  in  1  system clock (24 MHz HSOSC).
- `reset`  in  1  asynchronous, active-low reset.
- `rows`  in  4  keypad row lines, active-low (pulled up off-chip), asynchronous to `clk`.
- `cols`  out  4  keypad column drive, one-hot active-low.
- `digit_new`  out  4  hex code of the most recently accepted key.
- `digit_old`  out  4  hex code of the key accepted before `digit_new`.
- `key_valid`  out  1  one-cycle pulse when a key is accepted.

## Operation
- **Synchronizer:** `rows` pass through a 2-flop synchronizer into `rows_s`. All decisions use `rows_s` only.
- **Tick generator:** a free-running counter emits a one-cycle `tick` every `SCAN_DIV` cycles. All FSM transitions happen only on `tick` cycles.
- **Column index:**
  - `col_idx` is 2 bits.
  - `cols` = all-ones with bit `col_idx` low.
- **Key map** (row r, col c, code):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- **FSM states:**
  - **SCAN:**
    - On tick with `rows_s` = 4'hF: `col_idx` increments, wrapping 3→0.
    - Otherwise: latch `row_idx` (lowest-index low row if several are low), hold `col_idx`, clear `db_cnt`, go to PRESS_DB.
  - **PRESS_DB:**
    - On tick with `rows_s[row_idx]` low: `db_cnt`++. When `db_cnt` reaches `DEBOUNCE_TICKS`:
      - `digit_old` ← `digit_new`
      - `digit_new` ← code(`row_idx`, `col_idx`)
      - `key_valid` ← 1 for one cycle
      - go to HELD
    - On tick with `rows_s[row_idx]` high: go to SCAN with `col_idx` unchanged. No commit.
  - **HELD:**
    - On tick with `rows_s[row_idx]` high: clear `db_cnt`, go to REL_DB.
    - Otherwise stay in HELD.
  - **REL_DB:**
    - On tick with `rows_s[row_idx]` high: `db_cnt`++. When it reaches `DEBOUNCE_TICKS`: go to SCAN and advance `col_idx`.
    - On tick with `rows_s[row_idx]` low: return to HELD. No commit.
- **Column hold:** `col_idx` is frozen in PRESS_DB, HELD and REL_DB, so only the captured key is observed.
- **Ignored activity:** other keys pressed during PRESS_DB, HELD or REL_DB are ignored, including keys in the same column on other rows.
- **Counter width:** `db_cnt` is wide enough for `DEBOUNCE_TICKS` and saturates, never wraps.

## Timing
- **Reset values:**
  - state = SCAN, `col_idx` = 0, so `cols` = 4'b1110
  - `digit_new` = 0, `digit_old` = 0, `key_valid` = 0
  - tick counter, `db_cnt` and synchronizer flops = 0 / all-ones as appropriate (sync flops reset to 4'hF)
- **Input latency:** a `rows` change is visible in `rows_s` 2 cycles later.
- **Commit timing:** with the key stable low from capture tick T0, commit happens on tick T0 + `DEBOUNCE_TICKS`. `key_valid` and the updated digits appear on the clk edge ending that tick cycle, and `key_valid` is high for exactly 1 cycle.
- **Worst-case press latency** (stable press to `key_valid`): (4 + `DEBOUNCE_TICKS`) × `SCAN_DIV` + 3 cycles.
- **Digit updates:** `digit_new` and `digit_old` change only on commit and update in the same cycle.
- **Reset mid-operation:** asserting `reset` in any state immediately forces all reset values. No partial commit occurs and no `key_valid` pulse is emitted.
- **Simultaneous events:** a bounce edge landing on the commit tick is judged on that tick's `rows_s` value only.

## Test plan
Bench uses `SCAN_DIV` = 4, `DEBOUNCE_TICKS` = 3, and a keypad model that pulls row r low when column c is driven low and key (r, c) is pressed.
1. **Reset:** hold `reset` low 10 cycles, then release → `cols` = 4'b1110, digits = 0/0, `key_valid` = 0. `cols` then cycles 1110→1101→1011→0111→1110 every 4 cycles.
2. **Clean press of '5' (r1, c1):** → exactly one `key_valid` pulse; `digit_new` = 5, `digit_old` = 0; `cols` stays 4'b1101 while held.
3. **Second key after release, press 'A' (r0, c3):** → `digit_new` = A, `digit_old` = 5, one pulse.
4. **Short glitch:** '9' low for 2 ticks then high → no pulse, digits unchanged, scanning resumes.
5. **Bouncy hold and extra key:** hold '0' for 200 ticks with 1-tick bounces at press and release, and press '7' mid-hold → exactly one pulse; `digit_new` = 0; '7' is never registered.
6. **Reset mid-debounce:** assert `reset` during PRESS_DB of 'F' → digits = 0/0, no pulse, FSM in SCAN with `cols` = 4'b1110.
